// File: rtl/bsg_bp_dram_interleave_2x.sv
// Two-way cache-block interleave between the core memory port and two DRAM links.
// Commands are steered by one address bit; responses return to the core in command order.
module bsg_bp_dram_interleave_2x #(
  parameter int msg_width_p       = 128,
  parameter int addr_lsb_p        = 4,
  parameter int interleave_bit_p  = 6,
  parameter int max_outstanding_p = 8
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [msg_width_p-1:0]                   cmd_i,
  input  logic                                     cmd_v_i,
  output logic                                     cmd_ready_o,
  output logic [msg_width_p-1:0]                   resp_o,
  output logic                                     resp_v_o,
  input  logic                                     resp_yumi_i,
  output logic [1:0][msg_width_p-1:0]              link_cmd_o,
  output logic [1:0]                               link_cmd_v_o,
  input  logic [1:0]                               link_cmd_ready_i,
  input  logic [1:0][msg_width_p-1:0]              link_resp_i,
  input  logic [1:0]                               link_resp_v_i,
  output logic [1:0]                               link_resp_yumi_o,
  output logic [$clog2(max_outstanding_p+1)-1:0]   outstanding_o,
  output logic                                     error_o
);

  localparam int dest_bit_lp = addr_lsb_p + interleave_bit_p;
  localparam int ptr_w_lp    = $clog2(max_outstanding_p);
  localparam int cnt_w_lp    = $clog2(max_outstanding_p+1);

  // Handshakes: a transfer happens on a cycle where valid and ready (or valid and yumi)
  // are both high; valid never waits on ready, and cmd_ready_o depends only on flops.

  logic [1:0][msg_width_p-1:0] in_mem_r;
  logic                        in_rd_r, in_wr_r;
  logic [1:0]                  in_count_r;
  logic                        live_r;
  logic                        in_push, in_empty, in_full;
  logic [msg_width_p-1:0]      head;
  logic                        dest, can_issue, dispatch;

  logic [max_outstanding_p-1:0] ord_mem_r;
  logic [ptr_w_lp:0]            ord_rd_r, ord_wr_r;
  logic [cnt_w_lp-1:0]          count_r;
  logic                         ord_empty, head_link, resp_pop;

  logic stray, stray_r, error_r;

  assign in_empty    = (in_count_r == 2'd0);
  assign in_full     = (in_count_r == 2'd2);
  assign cmd_ready_o = live_r & ~in_full;
  assign in_push     = cmd_v_i & cmd_ready_o;

  assign head      = in_mem_r[in_rd_r];
  assign dest      = head[dest_bit_lp];
  // The credit compare uses the registered count, so a same-cycle pop frees nothing.
  assign can_issue = ~in_empty & (count_r < cnt_w_lp'(max_outstanding_p));
  assign dispatch  = can_issue & link_cmd_ready_i[dest];

  assign link_cmd_o[0]   = head;
  assign link_cmd_o[1]   = head;
  assign link_cmd_v_o[0] = can_issue & ~dest;
  assign link_cmd_v_o[1] = can_issue & dest;

  assign ord_empty = (ord_rd_r == ord_wr_r);
  assign head_link = ord_mem_r[ord_rd_r[ptr_w_lp-1:0]];

  assign resp_o              = link_resp_i[head_link];
  assign resp_v_o            = ~ord_empty & link_resp_v_i[head_link];
  assign resp_pop            = resp_v_o & resp_yumi_i;
  assign link_resp_yumi_o[0] = resp_pop & ~head_link;
  assign link_resp_yumi_o[1] = resp_pop & head_link;

  assign outstanding_o = count_r;
  assign error_o       = error_r;
  assign stray         = (|link_resp_v_i) & ord_empty;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      in_mem_r   <= '0;
      in_rd_r    <= 1'b0;
      in_wr_r    <= 1'b0;
      in_count_r <= 2'd0;
      live_r     <= 1'b0;
    end else begin
      live_r <= 1'b1;
      if (in_push) begin
        in_mem_r[in_wr_r] <= cmd_i;
        in_wr_r           <= ~in_wr_r;
      end
      if (dispatch) in_rd_r <= ~in_rd_r;
      in_count_r <= in_count_r + 2'(in_push) - 2'(dispatch);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ord_mem_r <= '0;
      ord_rd_r  <= '0;
      ord_wr_r  <= '0;
      count_r   <= '0;
    end else begin
      if (dispatch) begin
        ord_mem_r[ord_wr_r[ptr_w_lp-1:0]] <= dest;
        ord_wr_r <= ord_wr_r + 1'b1;
      end
      if (resp_pop) ord_rd_r <= ord_rd_r + 1'b1;
      count_r <= count_r + cnt_w_lp'(dispatch) - cnt_w_lp'(resp_pop);
    end
  end

  // A single stray cycle is tolerated; two in a row with nothing outstanding is an error.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stray_r <= 1'b0;
      error_r <= 1'b0;
    end else begin
      stray_r <= stray;
      error_r <= error_r | (stray & stray_r) | (resp_yumi_i & ~resp_v_o);
    end
  end

endmodule

// File: tb/tb_bsg_bp_dram_interleave_2x.sv
// Bench for bsg_bp_dram_interleave_2x: routing table, directed corner sequences,
// and a long random run against queue-based link and core models.
module tb_bsg_bp_dram_interleave_2x;
  localparam int W  = 128;
  localparam int AL = 4;
  localparam int IB = 6;
  localparam int MO = 8;
  localparam int DB = AL + IB;
  localparam int CW = $clog2(MO+1);
  localparam int N_RAND = 10000;

  logic              clk, reset_i;
  logic [W-1:0]      cmd_i;
  logic              cmd_v_i, cmd_ready_o;
  logic [W-1:0]      resp_o;
  logic              resp_v_o, resp_yumi_i;
  logic [1:0][W-1:0] link_cmd_o;
  logic [1:0]        link_cmd_v_o, link_cmd_ready_i;
  logic [1:0][W-1:0] link_resp_i;
  logic [1:0]        link_resp_v_i, link_resp_yumi_o;
  logic [CW-1:0]     outstanding_o;
  logic              error_o;

  bsg_bp_dram_interleave_2x #(
    .msg_width_p(W), .addr_lsb_p(AL), .interleave_bit_p(IB), .max_outstanding_p(MO)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .cmd_i(cmd_i), .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o),
    .resp_o(resp_o), .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i),
    .link_cmd_o(link_cmd_o), .link_cmd_v_o(link_cmd_v_o), .link_cmd_ready_i(link_cmd_ready_i),
    .link_resp_i(link_resp_i), .link_resp_v_i(link_resp_v_i), .link_resp_yumi_o(link_resp_yumi_o),
    .outstanding_o(outstanding_o), .error_o(error_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    bit          link;
  } vec_t;
  vec_t vecs[6];

  logic [W-1:0] exp_q[$];
  logic [W-1:0] disp_q[$];
  logic [W-1:0] lq0[$];
  logic [W-1:0] lq1[$];
  bit           exp_l[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_cmd(input logic [31:0] addr, input logic [31:0] tag);
    logic [W-1:0] m;
    m = {tag, ~tag, tag ^ 32'h1234_5678, 32'h0};
    m[AL +: 32] = addr;
    return m;
  endfunction

  function automatic logic [W-1:0] link_mask(input bit l);
    return l ? {4{32'h5a5a_0303}} : {4{32'h0f0f_0000}};
  endfunction

  function automatic logic [W-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [1:0] onehot(input bit l);
    return l ? 2'b10 : 2'b01;
  endfunction

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cmd_i            = '0;
    cmd_v_i          = 1'b0;
    resp_yumi_i      = 1'b0;
    link_cmd_ready_i = 2'b00;
    link_resp_i      = '0;
    link_resp_v_i    = 2'b00;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    idle_inputs();
    #1;
    check("rst_cmd_ready", W'(cmd_ready_o), 0);
    check("rst_link_cmd_v", W'(link_cmd_v_o), 0);
    check("rst_resp_v", W'(resp_v_o), 0);
    check("rst_link_resp_yumi", W'(link_resp_yumi_o), 0);
    check("rst_outstanding", W'(outstanding_o), 0);
    check("rst_error", W'(error_o), 0);
    cyc();
    cyc();
    reset_i = 1'b0;
    cyc();
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!cmd_ready_o && k < 50) begin
      cyc();
      k++;
    end
    check("cmd_ready_wait", W'(cmd_ready_o), 1);
  endtask

  task automatic send(input logic [W-1:0] m);
    cmd_i   = m;
    cmd_v_i = 1'b1;
    #1;
    wait_ready();
    cyc();
    cmd_v_i = 1'b0;
  endtask

  task automatic run_random();
    bit           cmd_pend;
    bit [1:0]     rhold;
    int           sent, cyc_n;
    bit           d, l;
    logic [W-1:0] m;
    cmd_pend = 0;
    rhold    = 2'b00;
    sent     = 0;
    cyc_n    = 0;
    while ((sent < N_RAND || cmd_pend || exp_q.size() > 0) && cyc_n < 90000) begin
      check("rand_outstanding", W'(outstanding_o), W'(lq0.size() + lq1.size()));
      if (!cmd_pend && sent < N_RAND && $urandom_range(3) != 0) begin
        m = rand128();
        cmd_i    = m;
        cmd_pend = 1;
        sent++;
      end
      cmd_v_i = cmd_pend;
      link_cmd_ready_i = {($urandom_range(3) != 0), ($urandom_range(3) != 0)};
      if (!rhold[0] && lq0.size() > 0 && $urandom_range(2) != 0) rhold[0] = 1;
      if (!rhold[1] && lq1.size() > 0 && $urandom_range(2) != 0) rhold[1] = 1;
      link_resp_v_i  = rhold;
      link_resp_i[0] = rhold[0] ? (lq0[0] ^ link_mask(0)) : rand128();
      link_resp_i[1] = rhold[1] ? (lq1[0] ^ link_mask(1)) : rand128();
      #1;
      resp_yumi_i = resp_v_o & ($urandom_range(3) != 0);
      #1;
      if (link_cmd_v_o != 2'b00) begin
        if (disp_q.size() == 0) begin
          check("rand_spurious_dispatch", W'(link_cmd_v_o), 0);
        end else begin
          d = disp_q[0][DB];
          check("rand_dispatch_route", W'(link_cmd_v_o), W'(onehot(d)));
          check("rand_dispatch_data", link_cmd_o[d], disp_q[0]);
          if (link_cmd_v_o[d] && link_cmd_ready_i[d]) begin
            if (d) lq1.push_back(disp_q[0]);
            else   lq0.push_back(disp_q[0]);
            void'(disp_q.pop_front());
          end
        end
      end
      if (resp_yumi_i) begin
        if (exp_q.size() == 0) begin
          check("rand_spurious_resp", W'(resp_v_o), 0);
        end else begin
          l = exp_l[0];
          check("rand_resp_data", resp_o, exp_q[0]);
          check("rand_resp_yumi", W'(link_resp_yumi_o), W'(onehot(l)));
          void'(exp_q.pop_front());
          void'(exp_l.pop_front());
          if (l) begin
            if (lq1.size() > 0) void'(lq1.pop_front());
          end else begin
            if (lq0.size() > 0) void'(lq0.pop_front());
          end
          rhold[l] = 0;
        end
      end else begin
        check("rand_resp_idle_yumi", W'(link_resp_yumi_o), 0);
      end
      if (cmd_v_i && cmd_ready_o) begin
        disp_q.push_back(cmd_i);
        exp_q.push_back(cmd_i ^ link_mask(cmd_i[DB]));
        exp_l.push_back(cmd_i[DB]);
        cmd_pend = 0;
      end
      cyc();
      cyc_n++;
    end
    idle_inputs();
    check("rand_completed_in_budget", W'(cyc_n < 90000), 1);
    check("rand_error_clear", W'(error_o), 0);
    check("rand_final_outstanding", W'(outstanding_o), 0);
  endtask

  initial begin
    logic [W-1:0] m, r0, r1;
    vecs[0] = '{32'h0000_0000, 1'b0};
    vecs[1] = '{32'h0000_0040, 1'b1};
    vecs[2] = '{32'h0000_0080, 1'b0};
    vecs[3] = '{32'h0000_03ff, 1'b1};
    vecs[4] = '{32'h0000_07bf, 1'b0};
    vecs[5] = '{32'hffff_ffc0, 1'b1};

    @(negedge clk);
    do_reset();

    // back-to-back commands to link 0 then link 1, links always ready
    link_cmd_ready_i = 2'b11;
    cmd_i   = mk_cmd(32'h000, 1);
    cmd_v_i = 1'b1;
    #1;
    check("t1_cmd_ready", W'(cmd_ready_o), 1);
    cyc();
    cmd_i = mk_cmd(32'h040, 2);
    #1;
    check("t1_link0_v", W'(link_cmd_v_o), 2'b01);
    check("t1_link0_data", link_cmd_o[0], mk_cmd(32'h000, 1));
    cyc();
    cmd_v_i = 1'b0;
    #1;
    check("t1_link1_v", W'(link_cmd_v_o), 2'b10);
    check("t1_link1_data", link_cmd_o[1], mk_cmd(32'h040, 2));
    cyc();
    #1;
    check("t1_idle_v", W'(link_cmd_v_o), 0);
    check("t1_outstanding", W'(outstanding_o), 2);

    // link 1 answers first; it must wait behind link 0
    link_cmd_ready_i = 2'b00;
    r0 = rand128();
    r1 = rand128();
    link_resp_i[1]   = r1;
    link_resp_v_i    = 2'b10;
    #1;
    check("t2_nonhead_resp_v", W'(resp_v_o), 0);
    check("t2_nonhead_yumi", W'(link_resp_yumi_o), 0);
    cyc();
    #1;
    check("t2_nonhead_still_held", W'(resp_v_o), 0);
    check("t2_outstanding", W'(outstanding_o), 2);
    link_resp_i[0] = r0;
    link_resp_v_i  = 2'b11;
    #1;
    check("t2_first_resp_v", W'(resp_v_o), 1);
    check("t2_first_resp_data", resp_o, r0);
    resp_yumi_i = 1'b1;
    #1;
    check("t2_first_yumi", W'(link_resp_yumi_o), 2'b01);
    cyc();
    link_resp_v_i = 2'b10;
    #1;
    check("t2_second_resp_data", resp_o, r1);
    check("t2_second_yumi", W'(link_resp_yumi_o), 2'b10);
    cyc();
    link_resp_v_i = 2'b00;
    resp_yumi_i   = 1'b0;
    #1;
    check("t2_outstanding_end", W'(outstanding_o), 0);
    check("t2_error", W'(error_o), 0);

    // routing table: each command alone, held on a busy link, then answered
    for (int i = 0; i < 6; i++) begin
      m = mk_cmd(vecs[i].addr, 32'h100 + i);
      cmd_i   = m;
      cmd_v_i = 1'b1;
      #1;
      check("vec_cmd_ready", W'(cmd_ready_o), 1);
      cyc();
      cmd_v_i = 1'b0;
      #1;
      check("vec_route_v", W'(link_cmd_v_o), W'(onehot(vecs[i].link)));
      check("vec_route_data", link_cmd_o[vecs[i].link], m);
      cyc();
      #1;
      check("vec_route_hold", W'(link_cmd_v_o), W'(onehot(vecs[i].link)));
      link_cmd_ready_i = 2'b11;
      cyc();
      link_cmd_ready_i = 2'b00;
      #1;
      check("vec_dispatched_v", W'(link_cmd_v_o), 0);
      check("vec_outstanding", W'(outstanding_o), 1);
      link_resp_i[vecs[i].link] = ~m;
      link_resp_v_i = onehot(vecs[i].link);
      #1;
      check("vec_resp_data", resp_o, ~m);
      resp_yumi_i = 1'b1;
      #1;
      check("vec_resp_yumi", W'(link_resp_yumi_o), W'(onehot(vecs[i].link)));
      cyc();
      link_resp_v_i = 2'b00;
      resp_yumi_i   = 1'b0;
      #1;
      check("vec_outstanding_end", W'(outstanding_o), 0);
    end

    // fill all credits; ninth command waits until one response is consumed
    link_cmd_ready_i = 2'b11;
    for (int k = 0; k < 9; k++) send(mk_cmd(32'h0, 32'h200 + k));
    cyc();
    cyc();
    #1;
    check("t3_full_outstanding", W'(outstanding_o), MO);
    check("t3_full_stall", W'(link_cmd_v_o), 0);
    r0 = rand128();
    link_resp_i[0] = r0;
    link_resp_v_i  = 2'b01;
    #1;
    resp_yumi_i = 1'b1;
    #1;
    check("t3_no_same_cycle_credit", W'(link_cmd_v_o), 0);
    check("t3_pop_yumi", W'(link_resp_yumi_o), 2'b01);
    cyc();
    link_resp_v_i = 2'b00;
    resp_yumi_i   = 1'b0;
    #1;
    check("t3_after_pop_outstanding", W'(outstanding_o), MO - 1);
    check("t3_ninth_issues", W'(link_cmd_v_o), 2'b01);
    cyc();
    #1;
    check("t3_refilled", W'(outstanding_o), MO);
    for (int k = 0; k < MO; k++) begin
      link_resp_i[0] = r0 ^ W'(k);
      link_resp_v_i  = 2'b01;
      resp_yumi_i    = 1'b1;
      #1;
      check("t3_drain_data", resp_o, r0 ^ W'(k));
      cyc();
    end
    link_resp_v_i    = 2'b00;
    resp_yumi_i      = 1'b0;
    link_cmd_ready_i = 2'b00;
    #1;
    check("t3_drained", W'(outstanding_o), 0);

    // head-of-line: link 0 busy blocks a following link 1 command
    send(mk_cmd(32'h000, 32'h300));
    send(mk_cmd(32'h040, 32'h301));
    #1;
    check("t4_in_fifo_full", W'(cmd_ready_o), 0);
    link_cmd_ready_i = 2'b10;
    #1;
    check("t4_head_blocks", W'(link_cmd_v_o), 2'b01);
    cyc();
    cyc();
    #1;
    check("t4_none_issued", W'(outstanding_o), 0);
    link_cmd_ready_i = 2'b11;
    cyc();
    #1;
    check("t4_second_now", W'(link_cmd_v_o), 2'b10);
    check("t4_one_out", W'(outstanding_o), 1);
    cyc();
    link_cmd_ready_i = 2'b00;
    #1;
    check("t4_two_out", W'(outstanding_o), 2);
    r0 = rand128();
    r1 = rand128();
    link_resp_i   = {r1, r0};
    link_resp_v_i = 2'b11;
    resp_yumi_i   = 1'b1;
    #1;
    check("t4_resp0", resp_o, r0);
    cyc();
    link_resp_v_i = 2'b10;
    #1;
    check("t4_resp1", resp_o, r1);
    cyc();
    link_resp_v_i = 2'b00;
    resp_yumi_i   = 1'b0;
    #1;
    check("t4_drained", W'(outstanding_o), 0);

    // reset with three outstanding, then a late response
    link_cmd_ready_i = 2'b11;
    for (int k = 0; k < 3; k++) send(mk_cmd(32'h0, 32'h400 + k));
    cyc();
    #1;
    check("t5_three_out", W'(outstanding_o), 3);
    link_resp_i[0] = rand128();
    link_resp_v_i  = 2'b01;
    cmd_i          = mk_cmd(32'h40, 32'h500);
    cmd_v_i        = 1'b1;
    #1;
    check("t5_resp_v_before", W'(resp_v_o), 1);
    #1;
    reset_i = 1'b1;
    #1;
    check("t5_async_outstanding", W'(outstanding_o), 0);
    check("t5_async_resp_v", W'(resp_v_o), 0);
    check("t5_async_cmd_ready", W'(cmd_ready_o), 0);
    check("t5_async_link_v", W'(link_cmd_v_o), 0);
    cmd_v_i          = 1'b0;
    link_cmd_ready_i = 2'b00;
    cyc();
    cyc();
    reset_i = 1'b0;
    #1;
    check("t5_error_released", W'(error_o), 0);
    cyc();
    #1;
    check("t5_error_one_cycle", W'(error_o), 0);
    cyc();
    #1;
    check("t5_error_two_cycles", W'(error_o), 1);
    cyc();
    #1;
    check("t5_error_sticky", W'(error_o), 1);
    do_reset();
    resp_yumi_i = 1'b1;
    cyc();
    resp_yumi_i = 1'b0;
    #1;
    check("t5_yumi_without_valid", W'(error_o), 1);
    do_reset();

    // randomized traffic against the queue models
    run_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
